our_relay: RTL and testbench
============================

// Module: our_relay
// PURPOSE
//  Clocked model of an electromechanical relay. The coil is driven by `switch`; the
//  normally-open contact passes the `batt` supply to `out`. Instances chain output-to-coil
//  to form relay logic; for example, relay 1 `out` drives relay 2 `switch`.
//  Models pull-in and drop-out delays so chained stages show per-stage latency.
// PARAMETERS
//  PULL_IN_CYCLES   2   consecutive coil-high cycles needed to close the contact (>=1)
//  DROP_OUT_CYCLES  2   consecutive coil-low cycles needed to open the contact (>=1)
//  CNT_W            8   width of the internal delay counter; must hold max(PULL_IN,DROP_OUT)
//  ACT_W           16   width of the actuation counter (RELAY_STATS_EN only)
// PORTS
//  clk        in   1      single system clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  out        out  1      contact output = contact_closed & batt
//  switch     in   1      coil drive; X/Z is treated as 0
//  batt       in   1      contact supply level
//  act_count  out  ACT_W  number of completed closures (RELAY_STATS_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=OPEN, counter=0, contact_closed=0, out=0, act_count=0.
//    Reset asserted mid-transition aborts the transition at once. No partial state survives.
//  - FSM states:
//    OPEN: switch=1 -> PULLING, counter=1; if PULL_IN_CYCLES==1 -> CLOSED directly.
//    PULLING: switch=1 -> counter++; at counter==PULL_IN_CYCLES -> CLOSED.
//      switch=0 -> OPEN, counter=0. A glitch shorter than pull-in never closes the contact.
//    CLOSED: switch=0 -> RELEASING, counter=1; if DROP_OUT_CYCLES==1 -> OPEN directly.
//    RELEASING: switch=0 -> counter++; at counter==DROP_OUT_CYCLES -> OPEN.
//      switch=1 -> CLOSED, counter=0.
//  - contact_closed is registered. It is 1 in CLOSED and RELEASING, 0 in OPEN and PULLING.
//  - Latency: out rises PULL_IN_CYCLES clocks after switch rises, with switch held and batt=1.
//    out falls DROP_OUT_CYCLES clocks after switch falls.
//  - out = contact_closed & batt is combinational. Loss of batt drops out in the same cycle.
//    batt does not affect the FSM.
//  - Chained relays: total latency is the sum of per-stage pull-in (or drop-out) delays.
//  - Counter saturates at its terminal value; no wrap within a state.
// CONFIGURATION
//  RELAY_STATS_EN defined:
//    - Port act_count exists.
//    - It increments on each PULLING->CLOSED and OPEN->CLOSED transition.
//    - It saturates at all-ones and does not wrap. Reset clears it.
//    - RELEASING->CLOSED (bounce recovery) does not count.
//  RELAY_STATS_EN undefined:
//    - Port act_count and its counter are absent.
//    - All other behaviour is identical.
// TESTING
//  1 Reset: rst_n=0 with switch=1, batt=1 -> out=0; after release, out=1 exactly 2 clocks later.
//  2 Toggle, defaults: switch 0->1, held 10 clocks -> out=1 after 2 clocks;
//    switch 1->0 -> out=0 after 2 clocks.
//  3 Glitch: switch=1 for 1 clock, then 0 -> out stays 0; act_count (if EN) stays 0.
//  4 Supply: contact closed, batt 1->0 -> out=0 same cycle; batt 0->1 -> out=1 same cycle.
//  5 Two-relay chain (r1.out -> r2.switch, batt=1): switch1 0,1,0,1 every 10 clocks ->
//    r2.out follows switch1 with 4-clock delay on each edge.
//  6 RELAY_STATS_EN: 3 full closures -> act_count=3;
//    async reset mid-PULLING -> act_count=0, out=0 immediately.

Source files
------------

// File: rtl/our_relay.sv
// rtl/our_relay.sv - clocked relay model with pull-in/drop-out delays
// Optional closure counter on act_count when RELAY_STATS_EN is defined.
module our_relay #(
   parameter int PULL_IN_CYCLES  = 2,
   parameter int DROP_OUT_CYCLES = 2,
   parameter int CNT_W           = 8,
   parameter int ACT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             out,
   input  logic             switch,
   input  logic             batt
`ifdef RELAY_STATS_EN
   ,
   output logic [ACT_W-1:0] act_count
`endif
);

   typedef enum logic [1:0] {
      ST_OPEN,
      ST_PULLING,
      ST_CLOSED,
      ST_RELEASING
   } state_t;

   localparam logic [CNT_W-1:0] PULL_T = CNT_W'(PULL_IN_CYCLES);
   localparam logic [CNT_W-1:0] DROP_T = CNT_W'(DROP_OUT_CYCLES);

   if (PULL_IN_CYCLES < 1 || DROP_OUT_CYCLES < 1 || ACT_W < 1 ||
       (PULL_IN_CYCLES >> CNT_W) != 0 || (DROP_OUT_CYCLES >> CNT_W) != 0) begin : g_bad_params
      $error("our_relay: delays must be >=1 and fit in CNT_W; ACT_W must be >=1");
   end

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic             contact_closed;
   logic             coil;

   // Anything other than a clean 1 on the coil is treated as de-energised.
   assign coil    = (switch === 1'b1);
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_OPEN: begin
            if (coil) begin
               if (PULL_IN_CYCLES == 1) begin
                  state_nxt = ST_CLOSED;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = ST_PULLING;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end
         ST_PULLING: begin
            if (!coil) begin
               state_nxt = ST_OPEN;
               cnt_nxt   = '0;
            end else if (cnt_inc == PULL_T) begin
               state_nxt = ST_CLOSED;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt_inc;
            end
         end
         ST_CLOSED: begin
            if (!coil) begin
               if (DROP_OUT_CYCLES == 1) begin
                  state_nxt = ST_OPEN;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = ST_RELEASING;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end
         ST_RELEASING: begin
            if (coil) begin
               state_nxt = ST_CLOSED;
               cnt_nxt   = '0;
            end else if (cnt_inc == DROP_T) begin
               state_nxt = ST_OPEN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt_inc;
            end
         end
         default: begin
            state_nxt = ST_OPEN;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_OPEN;
         cnt            <= '0;
         contact_closed <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         contact_closed <= (state_nxt == ST_CLOSED) || (state_nxt == ST_RELEASING);
      end
   end

   assign out = contact_closed & batt;

`ifdef RELAY_STATS_EN
   logic [ACT_W-1:0] act_cnt;
   logic             closing;

   // Only a fresh closure counts; recovering from a bounce in RELEASING does not.
   assign closing = (state_nxt == ST_CLOSED) && ((state == ST_OPEN) || (state == ST_PULLING));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_cnt <= '0;
      end else if (closing && (act_cnt != '1)) begin
         act_cnt <= act_cnt + ACT_W'(1);
      end
   end

   assign act_count = act_cnt;
`endif

endmodule

// File: tb/tb_our_relay.sv
// tb/tb_our_relay.sv - self-checking bench for our_relay (default and RELAY_STATS_EN builds)
module tb_our_relay;

   logic clk = 1'b0;
   logic rst_n, sw, batt, sw_c, sw_f;
   logic out0, out_r1, out_r2, out_f;
`ifdef RELAY_STATS_EN
   logic [15:0] act0, act_r1, act_r2, act_f;
`endif
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   our_relay u_dut (
      .clk(clk), .rst_n(rst_n), .out(out0), .switch(sw), .batt(batt)
`ifdef RELAY_STATS_EN
      , .act_count(act0)
`endif
   );

   our_relay u_r1 (
      .clk(clk), .rst_n(rst_n), .out(out_r1), .switch(sw_c), .batt(1'b1)
`ifdef RELAY_STATS_EN
      , .act_count(act_r1)
`endif
   );

   our_relay u_r2 (
      .clk(clk), .rst_n(rst_n), .out(out_r2), .switch(out_r1), .batt(1'b1)
`ifdef RELAY_STATS_EN
      , .act_count(act_r2)
`endif
   );

   our_relay #(.PULL_IN_CYCLES(1), .DROP_OUT_CYCLES(3)) u_fast (
      .clk(clk), .rst_n(rst_n), .out(out_f), .switch(sw_f), .batt(1'b1)
`ifdef RELAY_STATS_EN
      , .act_count(act_f)
`endif
   );

   // Reference: a contact closes once the coil has been high for P consecutive
   // sampled edges while open, and opens after D consecutive low edges while closed.
   // Index 0=u_dut, 1=u_r1, 2=u_r2 (driven by model of r1), 3=u_fast.
   localparam int MP[4] = '{2, 2, 2, 1};
   localparam int MD[4] = '{2, 2, 2, 3};
   bit   m_closed[4];
   int   m_hi[4], m_lo[4], m_act[4];
   logic [3:0] m_in;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_closed[i] = 1'b0; m_hi[i] = 0; m_lo[i] = 0; m_act[i] = 0;
         end
      end else begin
         m_in[0] = (sw === 1'b1);
         m_in[1] = (sw_c === 1'b1);
         m_in[2] = m_closed[1];
         m_in[3] = (sw_f === 1'b1);
         for (int i = 0; i < 4; i++) begin
            if (m_in[i]) begin m_hi[i]++; m_lo[i] = 0; end
            else begin m_lo[i]++; m_hi[i] = 0; end
            if (!m_closed[i] && m_hi[i] >= MP[i]) begin
               m_closed[i] = 1'b1;
               if (m_act[i] < 65535) m_act[i]++;
            end else if (m_closed[i] && m_lo[i] >= MD[i]) begin
               m_closed[i] = 1'b0;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; sw = 1'b1; batt = 1'b1; sw_c = 1'b0; sw_f = 1'b0;
      #1;
      checks++;
      if (out0 !== 1'b0) begin failures++; $display("FAIL reset_out: got %b expected 0", out0); end
`ifdef RELAY_STATS_EN
      checks++;
      if (act0 !== 16'd0) begin failures++; $display("FAIL reset_act: got %0d expected 0", act0); end
`endif
      tick(2);
      checks++;
      if (out0 !== 1'b0) begin failures++; $display("FAIL reset_held: got %b expected 0", out0); end
      rst_n = 1'b1;
      tick(1);
      checks++;
      if (out0 !== 1'b0) begin failures++; $display("FAIL reset_lat1: got %b expected 0", out0); end
      tick(1);
      checks++;
      if (out0 !== 1'b1) begin failures++; $display("FAIL reset_lat2: got %b expected 1", out0); end
   endtask

   task automatic test_toggle();
      int rise, fall;
      sw = 1'b0; batt = 1'b1;
      tick(4);
      checks++;
      if (out0 !== 1'b0) begin failures++; $display("FAIL toggle_idle: got %b expected 0", out0); end
      sw = 1'b1; rise = 0;
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         if (out0 === 1'b1 && rise == 0) rise = k;
         checks++;
         if (out0 !== (m_closed[0] & batt)) begin failures++; $display("FAIL toggle_on_model: cycle %0d got %b expected %b", k, out0, m_closed[0] & batt); end
      end
      checks++;
      if (rise != 2) begin failures++; $display("FAIL toggle_rise_lat: got %0d expected 2", rise); end
      sw = 1'b0; fall = 0;
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         if (out0 === 1'b0 && fall == 0) fall = k;
      end
      checks++;
      if (fall != 2) begin failures++; $display("FAIL toggle_fall_lat: got %0d expected 2", fall); end
   endtask

   task automatic test_glitch();
      int act_before;
      sw = 1'b0; tick(3);
      act_before = m_act[0];
      sw = 1'b1; tick(1);
      sw = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         checks++;
         if (out0 !== 1'b0) begin failures++; $display("FAIL glitch_out: cycle %0d got %b expected 0", k, out0); end
      end
      checks++;
      if (m_act[0] != act_before) begin failures++; $display("FAIL glitch_model_act: got %0d expected %0d", m_act[0], act_before); end
`ifdef RELAY_STATS_EN
      checks++;
      if (act0 !== 16'(act_before)) begin failures++; $display("FAIL glitch_act: got %0d expected %0d", act0, act_before); end
`endif
   endtask

   task automatic test_supply();
      sw = 1'b1; batt = 1'b1; tick(3);
      checks++;
      if (out0 !== 1'b1) begin failures++; $display("FAIL supply_closed: got %b expected 1", out0); end
      #2 batt = 1'b0;
      #1;
      checks++;
      if (out0 !== 1'b0) begin failures++; $display("FAIL supply_loss: got %b expected 0", out0); end
      #1 batt = 1'b1;
      #0.5;
      checks++;
      if (out0 !== 1'b1) begin failures++; $display("FAIL supply_restore: got %b expected 1", out0); end
   endtask

   task automatic test_async_reset();
      sw = 1'b1; batt = 1'b1; tick(3);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out0 !== 1'b0) begin failures++; $display("FAIL async_reset_out: got %b expected 0", out0); end
      tick(1);
      rst_n = 1'b1;
      sw = 1'b0;
      tick(2);
   endtask

   task automatic test_chain();
      int t, t_edge, edges;
      logic prev;
      t = 0; t_edge = 0; edges = 0; prev = out_r2;
      for (int seg = 0; seg < 4; seg++) begin
         if (sw_c !== logic'(seg % 2)) t_edge = t;
         sw_c = logic'(seg % 2);
         for (int c = 0; c < 10; c++) begin
            tick(1); t++;
            checks++;
            if (out_r2 !== m_closed[2]) begin failures++; $display("FAIL chain_model: t=%0d got %b expected %b", t, out_r2, m_closed[2]); end
            if (out_r2 !== prev) begin
               edges++;
               checks++;
               if (t - t_edge != 4) begin failures++; $display("FAIL chain_latency: got %0d expected 4", t - t_edge); end
               prev = out_r2;
            end
         end
      end
      checks++;
      if (edges != 3) begin failures++; $display("FAIL chain_edges: got %0d expected 3", edges); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 2) == 0) sw = logic'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) sw = 1'bx;
         if ($urandom_range(0, 2) == 0) sw_f = logic'($urandom_range(0, 1));
         batt = ($urandom_range(0, 7) != 0);
         tick(1);
         checks++;
         if (out0 !== (m_closed[0] & batt)) begin failures++; $display("FAIL random_out: k=%0d got %b expected %b", k, out0, m_closed[0] & batt); end
         checks++;
         if (out_f !== m_closed[3]) begin failures++; $display("FAIL random_fast: k=%0d got %b expected %b", k, out_f, m_closed[3]); end
`ifdef RELAY_STATS_EN
         checks++;
         if (act0 !== 16'(m_act[0])) begin failures++; $display("FAIL random_act: k=%0d got %0d expected %0d", k, act0, m_act[0]); end
`endif
      end
      sw = 1'b0; sw_f = 1'b0; batt = 1'b1;
      tick(4);
   endtask

`ifdef RELAY_STATS_EN
   task automatic test_stats();
      rst_n = 1'b0; sw = 1'b0; batt = 1'b1;
      tick(1);
      rst_n = 1'b1;
      tick(2);
      for (int n = 0; n < 3; n++) begin
         sw = 1'b1; tick(4);
         sw = 1'b0; tick(4);
      end
      checks++;
      if (act0 !== 16'd3) begin failures++; $display("FAIL stats_three: got %0d expected 3", act0); end
      sw = 1'b1; tick(4);
      sw = 1'b0; tick(1);
      sw = 1'b1; tick(3);
      checks++;
      if (act0 !== 16'd4) begin failures++; $display("FAIL stats_bounce: got %0d expected 4", act0); end
      sw = 1'b0; tick(4);
      sw = 1'b1; tick(1);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (act0 !== 16'd0) begin failures++; $display("FAIL stats_reset_act: got %0d expected 0", act0); end
      checks++;
      if (out0 !== 1'b0) begin failures++; $display("FAIL stats_reset_out: got %b expected 0", out0); end
      tick(1);
      rst_n = 1'b1;
      sw = 1'b0;
      tick(2);
   endtask
`endif

   initial begin
      rst_n = 1'b0; sw = 1'b0; batt = 1'b1; sw_c = 1'b0; sw_f = 1'b0;
      test_reset();
      test_toggle();
      test_glitch();
      test_supply();
      test_async_reset();
      test_chain();
      test_random();
`ifdef RELAY_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
